// File: rtl/div_signed_sequencer.sv
// Signed/unsigned front/back-end for the 32-bit unsigned multi-cycle divider core.
// Handles operand magnitudes, result sign fix-up, divide-by-zero, overflow and core timeout.
module div_signed_sequencer #(
  parameter int W         = 32,
  parameter int START_CYC = 1,
  parameter int MAX_WAIT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_dbz,
  output logic         out_ovf,
  output logic         out_tmo,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_start,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_finish
);

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_FIX,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           div_start_q, div_start_d;
  logic [W-1:0]   out_q_q, out_q_d;
  logic [W-1:0]   out_r_q, out_r_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;
  logic           tmo_q, tmo_d;
  logic [W-1:0]   div_a_q, div_a_d;
  logic [W-1:0]   div_b_q, div_b_d;
  logic           neg_q_q, neg_q_d;
  logic           neg_r_q, neg_r_d;
  logic [SC_W-1:0] start_cnt_q, start_cnt_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    div_start_d = div_start_q;
    out_q_d     = out_q_q;
    out_r_d     = out_r_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    start_cnt_d = start_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          neg_q_d    = in_signed & (in_a[W-1] ^ in_b[W-1]);
          neg_r_d    = in_signed & in_a[W-1];
          div_a_d    = (in_signed && in_a[W-1]) ? -in_a : in_a;
          div_b_d    = (in_signed && in_b[W-1]) ? -in_b : in_b;
          if (in_b == '0) begin
            out_q_d     = '1;
            out_r_d     = in_a;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (in_signed && in_a == MIN_VAL && in_b == '1) begin
            out_q_d     = MIN_VAL;
            out_r_d     = '0;
            ovf_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            div_start_d = 1'b1;
            start_cnt_d = '0;
            state_d     = S_START;
          end
        end
      end
      S_START: begin
        if (start_cnt_q == SC_W'(START_CYC - 1)) begin
          div_start_d = 1'b0;
          wait_cnt_d  = '0;
          state_d     = S_WAIT;
        end else begin
          start_cnt_d = start_cnt_q + SC_W'(1);
        end
      end
      S_WAIT: begin
        // The first WAIT cycle may still show the finish flag of the previous operation.
        if (wait_cnt_q != '0 && div_finish) begin
          out_q_d = div_q;
          out_r_d = div_r;
          state_d = S_FIX;
        end else if (wait_cnt_q == WC_W'(MAX_WAIT - 1)) begin
          out_q_d     = '0;
          out_r_d     = '0;
          tmo_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_FIX: begin
        out_q_d     = neg_q_q ? -out_q_q : out_q_q;
        out_r_d     = neg_r_q ? -out_r_q : out_r_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
          tmo_d       = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_start_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      start_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_start_q <= div_start_d;
      out_q_q     <= out_q_d;
      out_r_q     <= out_r_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      start_cnt_q <= start_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign div_start = div_start_q;
  assign out_q     = out_q_q;
  assign out_r     = out_r_q;
  assign out_dbz   = dbz_q;
  assign out_ovf   = ovf_q;
  assign out_tmo   = tmo_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;

endmodule

// File: tb/tb_div_signed_sequencer.sv
// Self-checking bench for div_signed_sequencer: directed vector table, corner sequences
// and randomized requests against an arithmetic reference model and a behavioural divider core.
module tb_div_signed_sequencer;

  localparam int MAX_WAIT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_q, out_r;
  logic        out_dbz, out_ovf, out_tmo;
  logic [31:0] div_a, div_b;
  logic        div_start;
  logic [31:0] div_q, div_r;
  logic        div_finish;

  int errors = 0;
  int checks = 0;

  div_signed_sequencer #(.W(32), .START_CYC(1), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .out_ovf(out_ovf), .out_tmo(out_tmo),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_q(div_q), .div_r(div_r), .div_finish(div_finish)
  );

  always #5 clk = ~clk;

  // Behavioural core: start restarts it, the old finish flag lingers one extra cycle,
  // and the result registers only update when the new division completes.
  logic [31:0] core_a = '0, core_b = '0, core_q = '0, core_r = '0;
  logic        core_finish = 1'b0;
  logic        core_run = 1'b0;
  logic        force_low = 1'b0;
  int          core_cnt = 0;
  int          core_lat = 2;

  always @(posedge clk) begin
    if (div_start) begin
      core_a   <= div_a;
      core_b   <= div_b;
      core_cnt <= 0;
      core_run <= 1'b1;
    end else if (core_run) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 0) begin
        core_finish <= 1'b0;
      end else if (core_cnt == core_lat - 1) begin
        core_finish <= 1'b1;
        core_q      <= (core_b == 0) ? 32'hFFFFFFFF : core_a / core_b;
        core_r      <= (core_b == 0) ? core_a : core_a % core_b;
        core_run    <= 1'b0;
      end
    end
  end

  assign div_q      = core_q;
  assign div_r      = core_r;
  assign div_finish = core_finish & ~force_low;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    logic        tmo;
    int          lat;
    int          starts;
    logic [31:0] da;
    logic [31:0] db;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic with the bypass rules.
  // Core-path results appear 1 + START_CYC + (core_lat + 1) + 1 cycles after accept.
  function automatic vec_t modelVec(input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn, input int clat);
    vec_t v;
    v.a = a; v.b = b; v.sgn = sgn;
    v.dbz = 1'b0; v.ovf = 1'b0; v.tmo = 1'b0;
    v.da = (sgn && a[31]) ? -a : a;
    v.db = (sgn && b[31]) ? -b : b;
    if (b == 0) begin
      v.q = 32'hFFFFFFFF; v.r = a; v.dbz = 1'b1; v.lat = 1; v.starts = 0;
    end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      v.q = 32'h80000000; v.r = 0; v.ovf = 1'b1; v.lat = 1; v.starts = 0;
    end else begin
      if (sgn) begin
        v.q = $signed(a) / $signed(b);
        v.r = $signed(a) % $signed(b);
      end else begin
        v.q = a / b;
        v.r = a % b;
      end
      v.lat = 4 + clat;
      v.starts = 1;
    end
    return v;
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " div_start"}, 32'(div_start), 32'd0);
    checkOutput({tag, " out_q"}, out_q, 32'd0);
    checkOutput({tag, " out_r"}, out_r, 32'd0);
    checkOutput({tag, " div_a"}, div_a, 32'd0);
    checkOutput({tag, " div_b"}, div_b, 32'd0);
    checkOutput({tag, " flags"}, {29'd0, out_dbz, out_ovf, out_tmo}, 32'd0);
  endtask

  // One full request/response transaction; holds out_ready low for 'hold' extra DONE cycles.
  task automatic applyStimulus(input vec_t v, input int hold, input string name);
    int lat;
    int starts;
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_a = v.a; in_b = v.b; in_signed = v.sgn; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom_range(0, 1));
    lat = 1;
    starts = 0;
    while (!out_valid && lat < 300) begin
      if (div_start) begin
        starts++;
        checkOutput({name, " div_a"}, div_a, v.da);
        checkOutput({name, " div_b"}, div_b, v.db);
      end
      @(negedge clk);
      lat++;
    end
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, " latency"}, 32'(lat), 32'(v.lat));
    checkOutput({name, " div_start cycles"}, 32'(starts), 32'(v.starts));
    for (int h = 0; h <= hold; h++) begin
      checkOutput({name, " hold out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, " hold in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({name, " out_q"}, out_q, v.q);
      checkOutput({name, " out_r"}, out_r, v.r);
      checkOutput({name, " flags dbz/ovf/tmo"}, {29'd0, out_dbz, out_ovf, out_tmo},
                  {29'd0, v.dbz, v.ovf, v.tmo});
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, " released out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, " released in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, " released flags"}, {29'd0, out_dbz, out_ovf, out_tmo}, 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v;
    int   w;
    // a, b, sgn, q, r, dbz, ovf, tmo, lat, starts, da, db  (core_lat = 2 -> lat 6)
    tbl[0] = '{32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, 6, 1, 32'd10, 32'd3};
    tbl[1] = '{32'd7, 32'd32, 1'b0, 32'd0, 32'd7, 1'b0, 1'b0, 1'b0, 6, 1, 32'd7, 32'd32};
    tbl[2] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 6, 1, 32'd7, 32'd2};
    tbl[3] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 1'b0, 6, 1, 32'd7, 32'd2};
    tbl[4] = '{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 1'b0, 1, 0, 32'd5, 32'd0};
    tbl[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0, 1, 0, 32'h80000000, 32'd1};
    tbl[6] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 6, 1, 32'd7, 32'd2};
    tbl[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 6, 1, 32'h80000000, 32'hFFFFFFFF};

    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    core_lat = 2;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i], 0, $sformatf("vec%0d", i));
    end

    $display("[TB] stall with out_ready low for 10 cycles");
    applyStimulus(tbl[3], 10, "stall");

    $display("[TB] reset pulse during WAIT");
    core_lat = 30;
    @(negedge clk);
    in_a = 32'd100; in_b = 32'd7; in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid-op in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkReset("async reset");
    @(negedge clk);
    rst = 1'b0;
    core_lat = 2;
    applyStimulus(tbl[0], 0, "after reset");

    $display("[TB] core finish tied low");
    force_low = 1'b1;
    v = modelVec(32'd1000, 32'd9, 1'b0, 2);
    v.q = 32'd0; v.r = 32'd0; v.tmo = 1'b1; v.lat = 2 + MAX_WAIT;
    applyStimulus(v, 2, "timeout");
    force_low = 1'b0;

    $display("[TB] randomized requests");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        sgn;
      int          sel, clat;
      clat = $urandom_range(2, 8);
      core_lat = clat;
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h80000000; b = 32'hFFFFFFFF;
      end else if (sel < 6) begin
        b = $urandom_range(1, 100);
        if (sgn && (i % 2 == 1)) b = -b;
      end
      v = modelVec(a, b, sgn, clat);
      applyStimulus(v, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    checkOutput("final idle", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
